// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational cyclic-priority search: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N    = 16,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap so non-power-of-2 channel counts stay in range.
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx[SELW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin or fixed selection and a registered output slot.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned W    = 8,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  slot_state_e     state_q, state_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            rr_gnt_valid, fix_gnt_valid, gnt_valid;
  logic [SELW-1:0] rr_gnt_idx, fix_gnt_idx, gnt_idx;
  logic [N-1:0]    fix_req;
  logic            load;

  rr_arbiter #(.N(N), .SELW(SELW)) u_rr_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // Fixed mode masks the request vector down to sel; an out-of-range sel matches nothing.
  always_comb begin
    fix_req = '0;
    for (int unsigned i = 0; i < N; i++) begin
      fix_req[i] = in_valid[i] && (32'(sel) == i);
    end
  end

  rr_arbiter #(.N(N), .SELW(SELW)) u_fix_arb (
    .req       (fix_req),
    .ptr       ('0),
    .gnt_valid (fix_gnt_valid),
    .gnt_idx   (fix_gnt_idx)
  );

  always_comb begin
    load       = (state_q == SLOT_EMPTY) || out_ready;
    gnt_valid  = (mode == MODE_FIXED) ? fix_gnt_valid : rr_gnt_valid;
    gnt_idx    = (mode == MODE_FIXED) ? fix_gnt_idx   : rr_gnt_idx;

    in_ready   = '0;
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;

    if (load) begin
      if (gnt_valid) begin
        in_ready[gnt_idx] = !rst;
        state_d           = SLOT_FULL;
        out_data_d        = in_data[32'(gnt_idx)*W +: W];
        out_sel_d         = gnt_idx;
        ptr_d             = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
      end else begin
        state_d = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: 16- and 12-channel instances against a queue-free behavioural model.
module tb_rr_stream_mux;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_data = '0;
  logic [15:0]  in_valid = '0;
  logic         mode = 1'b0;
  logic [3:0]   sel = '0;
  logic         out_ready = 1'b0;

  logic [15:0]  rdy16;
  logic [7:0]   data16;
  logic [3:0]   sel16;
  logic         val16;
  logic [11:0]  rdy12;
  logic [7:0]   data12;
  logic [3:0]   sel12;
  logic         val12;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(16), .W(8)) dut16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy16),
    .mode(mode), .sel(sel), .out_data(data16), .out_sel(sel16), .out_valid(val16),
    .out_ready(out_ready)
  );

  rr_stream_mux #(.N(12), .W(8)) dut12 (
    .clk(clk), .rst(rst), .in_data(in_data[95:0]), .in_valid(in_valid[11:0]), .in_ready(rdy12),
    .mode(mode), .sel(sel), .out_data(data12), .out_sel(sel12), .out_valid(val12),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one output slot per instance, pointer as a plain integer.
  int   nch[2]    = '{16, 12};
  bit   m_full[2] = '{0, 0};
  int   m_data[2] = '{0, 0};
  int   m_sel[2]  = '{0, 0};
  int   m_ptr[2]  = '{0, 0};

  function automatic int grant(input int inst);
    int n;
    int c;
    n = nch[inst];
    if (mode) return (int'(sel) < n && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < n; k++) begin
      c = (m_ptr[inst] + k) % n;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_full[i] = 0; m_data[i] = 0; m_sel[i] = 0; m_ptr[i] = 0;
      end else begin
        g = grant(i);
        if (!m_full[i] || out_ready) begin
          if (g >= 0) begin
            m_full[i] = 1;
            m_data[i] = int'(in_data[g*8 +: 8]);
            m_sel[i]  = g;
            m_ptr[i]  = (g + 1) % nch[i];
          end else begin
            m_full[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [31:0] exp_rdy;
    for (int i = 0; i < 2; i++) begin
      g = grant(i);
      exp_rdy = (!rst && (!m_full[i] || out_ready) && g >= 0) ? (32'd1 << g) : 32'd0;
      if (i == 0) begin
        chk("m16_in_ready", 32'(rdy16), exp_rdy);
        chk("m16_out_valid", 32'(val16), 32'(m_full[0]));
        chk("m16_out_data", 32'(data16), m_data[0]);
        chk("m16_out_sel", 32'(sel16), m_sel[0]);
      end else begin
        chk("m12_in_ready", 32'(rdy12), exp_rdy);
        chk("m12_out_valid", 32'(val12), 32'(m_full[1]));
        chk("m12_out_data", 32'(data12), m_data[1]);
        chk("m12_out_sel", 32'(sel12), m_sel[1]);
      end
    end
  end

  initial begin
    int seq_a[4];
    seq_a = '{3, 12, 3, 12};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(val16), 0);
    chk("rst_out_data", 32'(data16), 0);
    chk("rst_out_sel", 32'(sel16), 0);
    chk("rst_in_ready", 32'(rdy16), 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(i);
    in_valid  = 16'hFFFF;
    out_ready = 1'b1;
    mode      = 1'b0;

    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("rr_all_sel", 32'(sel16), k % 16);
      chk("rr_all_data", 32'(data16), k % 16);
    end
    #2;
    in_valid = 16'h1008;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_pair_sel", 32'(sel16), seq_a[k]);
      chk("rr_single12_sel", 32'(sel12), 3);
    end
    #2;
    in_valid = 16'h0080;

    @(negedge clk);
    chk("stall_load_sel", 32'(sel16), 7);
    #2;
    out_ready = 1'b0;
    in_valid  = 16'hFFFF;
    repeat (5) begin
      @(negedge clk);
      chk("stall_sel", 32'(sel16), 7);
      chk("stall_data", 32'(data16), 8'hA7);
      chk("stall_in_ready", 32'(rdy16), 0);
    end
    #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_sel", 32'(sel16), 8);

    #2;
    mode = 1'b1;
    sel  = 4'd5;
    repeat (3) begin
      @(negedge clk);
      chk("fixed_sel", 32'(sel16), 5);
      chk("fixed_sel12", 32'(sel12), 5);
    end
    #2;
    mode = 1'b0;
    @(negedge clk);
    chk("mode_back_sel", 32'(sel16), 6);
    #2;
    mode = 1'b1;
    sel  = 4'd13;
    @(negedge clk);
    chk("sel_oob_valid12", 32'(val12), 0);
    chk("sel13_sel16", 32'(sel16), 13);
    @(negedge clk);
    chk("sel_oob_rdy12", 32'(rdy12), 0);

    #2;
    mode = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(val16), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid16", 32'(val16), 0);
    chk("async_rst_valid12", 32'(val12), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sel", 32'(sel16), 0);
    chk("post_rst_valid", 32'(val16), 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
